// File: rtl/fft_dif_bf_scheduler.sv
// Radix-2 DIF butterfly scheduler: walks k over N/2 butterflies per stage,
// drains the datapath pipeline between stages, pulses done at frame end.
module fft_dif_bf_scheduler #(
  parameter int N        = 8,
  parameter int LOG2N    = 3,
  parameter int AW       = 3,
  parameter int PIPE_LAT = 2,
  localparam int SW      = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bf_ready,
  output logic          bf_valid,
  output logic [AW-1:0] idx_a,
  output logic [AW-1:0] idx_b,
  output logic [AW-2:0] tw_idx,
  output logic [SW-1:0] stage,
  output logic          busy,
  output logic          done
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] CLAST = DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [DW-1:0] CONE  = DW'(1);
  localparam logic [AW-2:0] KLAST = '1;
  localparam logic [AW-2:0] KONE  = (AW-1)'(1);
  localparam logic [SW-1:0] SLAST = SW'(LOG2N - 1);
  localparam logic [SW-1:0] SONE  = SW'(1);
  localparam logic [AW-1:0] TOP   = AW'(LOG2N - 1);
  localparam logic [AW-1:0] AONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-2:0] k_q, k_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          last_stage;

  assign last_stage = (stage_q == SLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          k_d     = '0;
          stage_d = '0;
        end
      end
      ISSUE: begin
        if (bf_ready) begin
          if (k_q == KLAST) begin
            k_d   = '0;
            cnt_d = '0;
            if (PIPE_LAT > 0) state_d = DRAIN;
            else if (last_stage) state_d = DONE;
            else stage_d = stage_q + SONE;
          end else begin
            k_d = k_q + KONE;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CLAST) begin
          if (last_stage) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + SONE;
          end
        end else begin
          cnt_d = cnt_q + CONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // span = 2^shamt; a = (g << (shamt+1)) | j, b = a | span
  logic [AW-1:0] shamt, span, mask, kx, j, g, a;
  logic [AW-2:0] tw;
  logic          is_issue;

  always_comb begin
    shamt = TOP - AW'(stage_q);
    span  = AONE << shamt;
    mask  = span - AONE;
    kx    = {1'b0, k_q};
    j     = kx & mask;
    g     = kx >> shamt;
    a     = (g << (shamt + AONE)) | j;
    tw    = j[AW-2:0] << stage_q;
  end

  assign is_issue = (state_q == ISSUE);
  assign bf_valid = is_issue;
  assign idx_a    = is_issue ? a : '0;
  assign idx_b    = is_issue ? (a | span) : '0;
  assign tw_idx   = is_issue ? tw : '0;
  assign stage    = stage_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_fft_dif_bf_scheduler.sv
// Bench for fft_dif_bf_scheduler: three instances (N=8/PL=2, N=8/PL=0,
// N=16/PL=2) checked against an arithmetic address model.
module tb_fft_dif_bf_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bf_ready = 1'b0;
  logic start8 = 1'b0, start0 = 1'b0, start16 = 1'b0;

  logic       bv8, busy8, done8;
  logic [2:0] ia8, ib8;
  logic [1:0] tw8, st8;
  logic       bv0, busy0, done0;
  logic [2:0] ia0, ib0;
  logic [1:0] tw0, st0;
  logic       bv16, busy16, done16;
  logic [3:0] ia16, ib16;
  logic [2:0] tw16;
  logic [1:0] st16;

  fft_dif_bf_scheduler #(.N(8), .LOG2N(3), .AW(3), .PIPE_LAT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bf_ready(bf_ready),
    .bf_valid(bv8), .idx_a(ia8), .idx_b(ib8), .tw_idx(tw8),
    .stage(st8), .busy(busy8), .done(done8));

  fft_dif_bf_scheduler #(.N(8), .LOG2N(3), .AW(3), .PIPE_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bf_ready(bf_ready),
    .bf_valid(bv0), .idx_a(ia0), .idx_b(ib0), .tw_idx(tw0),
    .stage(st0), .busy(busy0), .done(done0));

  fft_dif_bf_scheduler #(.N(16), .LOG2N(4), .AW(4), .PIPE_LAT(2)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .bf_ready(bf_ready),
    .bf_valid(bv16), .idx_a(ia16), .idx_b(ib16), .tw_idx(tw16),
    .stage(st16), .busy(busy16), .done(done16));

  typedef struct {
    int a; int b; int tw; int st; int cyc; bit rdy;
  } op_t;

  op_t q8[$], q0[$], q16[$], refq[$];
  int  d8[$], d0[$], d16[$], bz8[$];
  int  cyc = 0;
  int  tests = 0, fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    op_t o;
    if (bv8) begin
      o.a = int'(ia8); o.b = int'(ib8); o.tw = int'(tw8);
      o.st = int'(st8); o.cyc = cyc; o.rdy = bf_ready;
      q8.push_back(o);
    end
    if (bv0) begin
      o.a = int'(ia0); o.b = int'(ib0); o.tw = int'(tw0);
      o.st = int'(st0); o.cyc = cyc; o.rdy = bf_ready;
      q0.push_back(o);
    end
    if (bv16) begin
      o.a = int'(ia16); o.b = int'(ib16); o.tw = int'(tw16);
      o.st = int'(st16); o.cyc = cyc; o.rdy = bf_ready;
      q16.push_back(o);
    end
    if (done8) d8.push_back(cyc);
    if (done0) d0.push_back(cyc);
    if (done16) d16.push_back(cyc);
    if (busy8) bz8.push_back(cyc);
  end

  // Reference butterfly order from the DIF definition, plain arithmetic.
  function automatic void build_ref(input int n);
    op_t o;
    int lg, span, j, g;
    refq.delete();
    lg = $clog2(n);
    for (int s = 0; s < lg; s++) begin
      span = n >> (s + 1);
      for (int k = 0; k < n / 2; k++) begin
        j = k % span;
        g = k / span;
        o.a = 2 * g * span + j;
        o.b = o.a + span;
        o.tw = j * (1 << s);
        o.st = s;
        o.cyc = 0;
        o.rdy = 1'b1;
        refq.push_back(o);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    q8.delete(); q0.delete(); q16.delete();
    d8.delete(); d0.delete(); d16.delete(); bz8.delete();
  endtask

  // Launch one frame on the selected instance; mode 1 randomizes bf_ready.
  task automatic run_frame(input int dut, input int mode,
                           output int t0, output bit tmo);
    clear_all();
    t0 = cyc;
    tmo = 1'b1;
    for (int c = 0; c < 400; c++) begin
      start8  = (dut == 0) && (c == 0);
      start0  = (dut == 1) && (c == 0);
      start16 = (dut == 2) && (c == 0);
      bf_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tick();
      if ((dut == 0 && d8.size() != 0) || (dut == 1 && d0.size() != 0) ||
          (dut == 2 && d16.size() != 0)) begin
        tmo = 1'b0;
        break;
      end
    end
    start8 = 0; start0 = 0; start16 = 0;
    bf_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests++;
    if ({bv8, ia8, ib8, tw8, st8, busy8, done8} !== '0) begin
      fails++;
      $display("FAIL reset_n8: got %h expected 0",
               {bv8, ia8, ib8, tw8, st8, busy8, done8});
    end
    tests++;
    if ({bv0, ia0, ib0, tw0, st0, busy0, done0} !== '0) begin
      fails++;
      $display("FAIL reset_pl0: got %h expected 0",
               {bv0, ia0, ib0, tw0, st0, busy0, done0});
    end
    tests++;
    if ({bv16, ia16, ib16, tw16, st16, busy16, done16} !== '0) begin
      fails++;
      $display("FAIL reset_n16: got %h expected 0",
               {bv16, ia16, ib16, tw16, st16, busy16, done16});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    int t0, n, rel;
    bit tmo;
    build_ref(8);
    run_frame(0, 0, t0, tmo);
    tests++;
    if (tmo) begin
      fails++;
      $display("FAIL frame_timeout: got no done expected done");
    end
    n = 0;
    foreach (q8[i]) begin
      if (q8[i].rdy && n < refq.size()) begin
        rel = 1 + (n / 4) * 6 + (n % 4);
        tests++;
        if (q8[i].a !== refq[n].a || q8[i].b !== refq[n].b ||
            q8[i].tw !== refq[n].tw || q8[i].st !== refq[n].st ||
            q8[i].cyc - t0 !== rel) begin
          fails++;
          $display("FAIL frame_op%0d: got a%0d b%0d tw%0d s%0d c%0d expected a%0d b%0d tw%0d s%0d c%0d",
                   n, q8[i].a, q8[i].b, q8[i].tw, q8[i].st, q8[i].cyc - t0,
                   refq[n].a, refq[n].b, refq[n].tw, refq[n].st, rel);
        end
      end
      if (q8[i].rdy) n++;
    end
    tests++;
    if (n !== 12) begin
      fails++;
      $display("FAIL frame_count: got %0d expected 12", n);
    end
    tests++;
    if (d8.size() !== 1 || (d8.size() > 0 && d8[0] - t0 !== 19)) begin
      fails++;
      $display("FAIL frame_done: got n=%0d c=%0d expected n=1 c=19",
               d8.size(), d8.size() > 0 ? d8[0] - t0 : -1);
    end
    tests++;
    if (bz8.size() !== 19 || bz8[0] - t0 !== 1 || bz8[18] - t0 !== 19) begin
      fails++;
      $display("FAIL frame_busy: got n=%0d expected 19 cycles 1..19", bz8.size());
    end
  endtask

  task automatic test_backpressure();
    int t0, n, held;
    clear_all();
    build_ref(8);
    t0 = cyc;
    for (int c = 0; c < 60; c++) begin
      start8 = (c == 0);
      bf_ready = !(c >= 2 && c <= 4);
      tick();
      if (d8.size() != 0) break;
    end
    start8 = 1'b0;
    bf_ready = 1'b1;
    tick();
    held = 0;
    foreach (q8[i]) begin
      if (q8[i].cyc - t0 >= 2 && q8[i].cyc - t0 <= 5 && q8[i].a == 1 &&
          q8[i].b == 5 && q8[i].tw == 1 && q8[i].st == 0) held++;
    end
    tests++;
    if (held !== 4) begin
      fails++;
      $display("FAIL bp_hold: got %0d cycles expected 4", held);
    end
    n = 0;
    foreach (q8[i]) begin
      if (q8[i].rdy) begin
        tests++;
        if (n >= refq.size() || q8[i].a !== refq[n].a ||
            q8[i].b !== refq[n].b || q8[i].tw !== refq[n].tw) begin
          fails++;
          $display("FAIL bp_op%0d: got a%0d b%0d tw%0d expected from model",
                   n, q8[i].a, q8[i].b, q8[i].tw);
        end
        n++;
      end
    end
    tests++;
    if (n !== 12 || d8.size() !== 1 || d8[0] - t0 !== 22) begin
      fails++;
      $display("FAIL bp_done: got n=%0d done=%0d expected n=12 done=22",
               n, d8.size() > 0 ? d8[0] - t0 : -1);
    end
  endtask

  task automatic test_random_stall();
    int t0, n, stalls, herr, nerr;
    bit tmo;
    build_ref(8);
    run_frame(0, 1, t0, tmo);
    stalls = 0; herr = 0; nerr = 0; n = 0;
    foreach (q8[i]) begin
      if (!q8[i].rdy) begin
        stalls++;
        if (i + 1 >= q8.size()) herr++;
        else if (q8[i+1].cyc != q8[i].cyc + 1 || q8[i+1].a != q8[i].a ||
                 q8[i+1].b != q8[i].b || q8[i+1].tw != q8[i].tw ||
                 q8[i+1].st != q8[i].st) herr++;
      end else begin
        if (n >= refq.size() || q8[i].a != refq[n].a ||
            q8[i].b != refq[n].b || q8[i].tw != refq[n].tw ||
            q8[i].st != refq[n].st) nerr++;
        n++;
      end
    end
    tests++;
    if (herr !== 0) begin
      fails++;
      $display("FAIL rnd_hold: got %0d unstable stalls expected 0", herr);
    end
    tests++;
    if (nerr !== 0 || n !== 12) begin
      fails++;
      $display("FAIL rnd_seq: got %0d bad of %0d expected 0 of 12", nerr, n);
    end
    tests++;
    if (tmo || d8.size() !== 1 || d8[0] - t0 !== 19 + stalls) begin
      fails++;
      $display("FAIL rnd_done: got %0d expected %0d",
               d8.size() > 0 ? d8[0] - t0 : -1, 19 + stalls);
    end
  endtask

  task automatic test_start_ignored();
    int t0, n, hit;
    clear_all();
    t0 = cyc;
    for (int c = 0; c <= 22; c++) begin
      start8 = (c == 0 || c == 5 || c == 19 || c == 20);
      bf_ready = 1'b1;
      tick();
    end
    start8 = 1'b0;
    n = 0; hit = 0;
    foreach (q8[i]) begin
      if (q8[i].rdy && q8[i].cyc - t0 <= 19) n++;
      if (q8[i].cyc - t0 == 21 && q8[i].a == 0 && q8[i].b == 4 &&
          q8[i].st == 0) hit++;
    end
    tests++;
    if (n !== 12) begin
      fails++;
      $display("FAIL restart_issues: got %0d expected 12", n);
    end
    tests++;
    if (d8.size() !== 1 || d8[0] - t0 !== 19) begin
      fails++;
      $display("FAIL restart_done: got n=%0d expected 1 at 19", d8.size());
    end
    tests++;
    if (hit !== 1) begin
      fails++;
      $display("FAIL restart_new: got %0d expected 1 issue at 21", hit);
    end
  endtask

  task automatic test_reset_mid();
    int t0, n, late, mid;
    bit tmo;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_all();
    t0 = cyc;
    for (int c = 0; c <= 7; c++) begin
      start8 = (c == 0);
      bf_ready = 1'b1;
      rst = (c == 7);
      tick();
    end
    start8 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bv8, ia8, ib8, tw8, st8, busy8, done8} !== '0) begin
      fails++;
      $display("FAIL midrst_zero: got %h expected 0",
               {bv8, ia8, ib8, tw8, st8, busy8, done8});
    end
    @(posedge clk);
    #1;
    tick();
    tick();
    late = 0; mid = 0;
    foreach (bz8[i]) if (bz8[i] - t0 >= 8) late++;
    foreach (q8[i])
      if (q8[i].cyc - t0 == 7 && q8[i].st == 1 && q8[i].b == 2) mid++;
    tests++;
    if (late !== 0 || d8.size() !== 0 || mid !== 1) begin
      fails++;
      $display("FAIL midrst_idle: got busy=%0d done=%0d s1=%0d expected 0 0 1",
               late, d8.size(), mid);
    end
    build_ref(8);
    run_frame(0, 0, t0, tmo);
    n = 0; mid = 0;
    foreach (q8[i]) begin
      if (n >= refq.size() || q8[i].a != refq[n].a || q8[i].b != refq[n].b ||
          q8[i].tw != refq[n].tw || q8[i].cyc - t0 != 1 + (n/4)*6 + n%4)
        mid++;
      n++;
    end
    tests++;
    if (tmo || mid !== 0 || n !== 12 || d8[0] - t0 !== 19) begin
      fails++;
      $display("FAIL midrst_replay: got %0d bad of %0d expected 0 of 12", mid, n);
    end
  endtask

  task automatic test_pipe0();
    int t0, n, bad;
    bit tmo;
    build_ref(8);
    run_frame(1, 0, t0, tmo);
    n = 0; bad = 0;
    foreach (q0[i]) begin
      if (n >= refq.size() || q0[i].a != refq[n].a || q0[i].b != refq[n].b ||
          q0[i].tw != refq[n].tw || q0[i].st != refq[n].st ||
          q0[i].cyc - t0 != 1 + n) bad++;
      n++;
    end
    tests++;
    if (bad !== 0 || n !== 12) begin
      fails++;
      $display("FAIL pl0_seq: got %0d bad of %0d expected 0 of 12", bad, n);
    end
    tests++;
    if (tmo || d0.size() !== 1 || d0[0] - t0 !== 13) begin
      fails++;
      $display("FAIL pl0_done: got %0d expected 13",
               d0.size() > 0 ? d0[0] - t0 : -1);
    end
  endtask

  task automatic test_n16();
    int t0, n, bad, stalls, tw3, tw0s;
    bit tmo;
    build_ref(16);
    run_frame(2, 1, t0, tmo);
    n = 0; bad = 0; stalls = 0; tw3 = 0; tw0s = 0;
    foreach (q16[i]) begin
      if (!q16[i].rdy) begin
        stalls++;
      end else begin
        if (n >= refq.size() || q16[i].a != refq[n].a ||
            q16[i].b != refq[n].b || q16[i].tw != refq[n].tw ||
            q16[i].st != refq[n].st) bad++;
        if (q16[i].st == 3 && q16[i].tw != 0) tw3++;
        if (q16[i].st == 0 && q16[i].tw != n) tw0s++;
        n++;
      end
    end
    tests++;
    if (bad !== 0 || n !== 32) begin
      fails++;
      $display("FAIL n16_seq: got %0d bad of %0d expected 0 of 32", bad, n);
    end
    tests++;
    if (tw3 !== 0 || tw0s !== 0) begin
      fails++;
      $display("FAIL n16_tw: got s3=%0d s0=%0d bad expected 0 0", tw3, tw0s);
    end
    tests++;
    if (tmo || d16.size() !== 1 || d16[0] - t0 !== 41 + stalls) begin
      fails++;
      $display("FAIL n16_done: got %0d expected %0d",
               d16.size() > 0 ? d16[0] - t0 : -1, 41 + stalls);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_random_stall();
    test_start_ignored();
    test_reset_mid();
    test_pipe0();
    test_n16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
